// File: rtl/gd_iter_ctrl.sv
// rtl/gd_iter_ctrl.sv - iteration controller for the fixed-point gradient-descent loop
module gd_iter_ctrl #(
    parameter int          MAX_ITER = 256,
    parameter int          ITER_W   = 16,
    parameter logic [31:0] TOL      = 32'h00000001,
    parameter int          WATCHDOG = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       x_init,
    input  logic [31:0]       x_diff,
    input  logic              func_done,
    input  logic              grad_overflow,
    output logic              start_func,
    output logic [31:0]       x_cur,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic              sat_seen
);

    localparam int WD_W = $clog2(WATCHDOG + 1);

    localparam logic [1:0] ST_CONV  = 2'd0;
    localparam logic [1:0] ST_MAX   = 2'd1;
    localparam logic [1:0] ST_OVF   = 2'd2;
    localparam logic [1:0] ST_TIMEO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BLANK,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state;
    logic [WD_W-1:0]   wd_cnt;
    logic [31:0]       x_diff_q;
    logic              ovf_q;

    logic signed [32:0] diff_33;
    logic [32:0]        diff_abs;
    logic [31:0]        x_sat;
    logic               sat_hi;
    logic               sat_lo;
    logic               converged;
    logic [ITER_W-1:0]  iter_next;
    logic               max_hit;

    // 33-bit difference keeps the true sign so clamping can be decided from the top two bits
    assign diff_33   = $signed({x_cur[31], x_cur}) - $signed({x_diff_q[31], x_diff_q});
    assign sat_hi    = (diff_33[32] == 1'b0) && (diff_33[31] == 1'b1);
    assign sat_lo    = (diff_33[32] == 1'b1) && (diff_33[31] == 1'b0);
    assign x_sat     = sat_hi ? 32'h7FFFFFFF : (sat_lo ? 32'h80000000 : diff_33[31:0]);
    assign diff_abs  = x_diff_q[31] ? (33'd0 - {1'b1, x_diff_q}) : {1'b0, x_diff_q};
    assign converged = diff_abs <= {1'b0, TOL};
    assign iter_next = iter_count + 1'b1;
    assign max_hit   = iter_next == ITER_W'(MAX_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_func <= 1'b0;
            x_cur      <= '0;
            iter_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= ST_CONV;
            sat_seen   <= 1'b0;
            wd_cnt     <= '0;
            x_diff_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            start_func <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x_cur      <= x_init;
                        iter_count <= '0;
                        sat_seen   <= 1'b0;
                        status     <= ST_CONV;
                        start_func <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_BLANK;
                end
                S_BLANK: begin
                    // func_done still shows the previous evaluation here, so it is not looked at
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (func_done) begin
                        x_diff_q <= x_diff;
                        ovf_q    <= grad_overflow;
                        state    <= S_UPDATE;
                    end else if (wd_cnt == WD_W'(WATCHDOG - 1)) begin
                        status <= ST_TIMEO;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (ovf_q) begin
                        status <= ST_OVF;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        x_cur      <= x_sat;
                        sat_seen   <= sat_seen | sat_hi | sat_lo;
                        iter_count <= iter_next;
                        if (converged) begin
                            status <= ST_CONV;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else if (max_hit) begin
                            status <= ST_MAX;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            start_func <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// tb/tb_gd_iter_ctrl.sv - directed and randomized checks of gd_iter_ctrl against a reference model
module tb_gd_iter_ctrl;

    localparam int          MAX_ITER = 4;
    localparam int          ITER_W   = 16;
    localparam logic [31:0] TOL      = 32'h00000001;
    localparam int          WD       = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       x_init = '0;
    logic [31:0]       x_diff = '0;
    logic              func_done = 1'b0;
    logic              grad_overflow = 1'b0;
    logic              start_func;
    logic [31:0]       x_cur;
    logic [ITER_W-1:0] iter_count;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic              sat_seen;

    int tests = 0;
    int fails = 0;

    logic [31:0] rq_diff[$];
    bit          rq_ovf[$];
    int          rq_lat[$];

    gd_iter_ctrl #(
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W),
        .TOL     (TOL),
        .WATCHDOG(WD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_init       (x_init),
        .x_diff       (x_diff),
        .func_done    (func_done),
        .grad_overflow(grad_overflow),
        .start_func   (start_func),
        .x_cur        (x_cur),
        .iter_count   (iter_count),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .sat_seen     (sat_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, x_cur, 32'h0);
        chk({tag, "_iter"}, 32'(iter_count), 32'h0);
        chk({tag, "_status"}, 32'(status), 32'h0);
        chk({tag, "_sat"}, 32'(sat_seen), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_sf"}, 32'(start_func), 32'h0);
    endtask

    task automatic push_resp(input logic [31:0] d, input bit o, input int lat);
        rq_diff.push_back(d);
        rq_ovf.push_back(o);
        rq_lat.push_back(lat);
    endtask

    task automatic clear_resp();
        rq_diff.delete();
        rq_ovf.delete();
        rq_lat.delete();
    endtask

    // Plain-arithmetic reference: walk the response list until one of the stop rules fires
    task automatic model(input logic [31:0] xi, output logic [31:0] xe, output int ie,
                         output int se, output bit sate, output int used);
        longint x, d, g, ag;
        x = longint'($signed(xi));
        ie = 0; se = 0; sate = 0; used = 0;
        for (int k = 0; k < rq_diff.size(); k++) begin
            used = k + 1;
            if (rq_ovf[k]) begin
                se = 2;
                break;
            end
            g = longint'($signed(rq_diff[k]));
            d = x - g;
            if (d > 64'sd2147483647) begin
                d = 64'sd2147483647; sate = 1;
            end else if (d < -64'sd2147483648) begin
                d = -64'sd2147483648; sate = 1;
            end
            x = d;
            ie++;
            ag = (g < 0) ? -g : g;
            if (ag <= longint'(TOL)) begin
                se = 0;
                break;
            end
            if (ie == MAX_ITER) begin
                se = 1;
                break;
            end
        end
        xe = x[31:0];
    endtask

    task automatic run(input string tag, input logic [31:0] xi, input bit rand_start);
        logic [31:0] xe;
        int ie, se, used, pulses, cnt, idx;
        bit sate, got;
        model(xi, xe, ie, se, sate, used);
        @(negedge clk);
        x_init = xi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_init = $urandom;
        pulses = 0; cnt = -1; idx = 0; got = 0;
        for (int cyc = 0; cyc < 400 && !got; cyc++) begin
            if (done) begin
                got = 1;
            end else begin
                if (start_func) begin
                    pulses++;
                    func_done = 1'b0;
                    cnt = (idx < rq_lat.size()) ? rq_lat[idx] : 1;
                end else if (cnt > 0) begin
                    cnt--;
                end
                if (cnt == 0) begin
                    x_diff = (idx < rq_diff.size()) ? rq_diff[idx] : 32'h0;
                    grad_overflow = (idx < rq_ovf.size()) ? rq_ovf[idx] : 1'b0;
                    func_done = 1'b1;
                    idx++;
                    cnt = -1;
                end
                if (rand_start) begin
                    start = 1'($urandom_range(0, 1));
                    x_init = $urandom;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(got), 32'h1);
        chk({tag, "_x"}, x_cur, xe);
        chk({tag, "_iter"}, 32'(iter_count), 32'(ie));
        chk({tag, "_status"}, 32'(status), 32'(se));
        chk({tag, "_sat"}, 32'(sat_seen), 32'(sate));
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_pulses"}, 32'(pulses), 32'(used));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'h0);
        chk({tag, "_x_hold"}, x_cur, xe);
    endtask

    initial begin
        int cyc;
        logic [31:0] xr;
        int r;

        // reset state
        #2;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("idle");

        // single-step convergence
        clear_resp();
        push_resp(32'h0, 1'b0, 3);
        run("conv1", 32'h00000400, 1'b0);

        // iteration limit
        clear_resp();
        for (int k = 0; k < MAX_ITER; k++) push_resp(32'h10, 1'b0, 2);
        run("maxit", 32'h00000100, 1'b0);

        // negative saturation then convergence
        clear_resp();
        push_resp(32'h7FFFFFFF, 1'b0, 1);
        push_resp(32'h0, 1'b0, 2);
        run("sat", 32'h80000010, 1'b0);

        // overflow on second result
        clear_resp();
        push_resp(32'h10, 1'b0, 2);
        push_resp(32'h10, 1'b1, 3);
        run("ovf", 32'h00000100, 1'b0);

        // stale func_done must be masked; then timeout
        func_done = 1'b1;
        x_diff = 32'h0;
        grad_overflow = 1'b0;
        @(negedge clk);
        x_init = 32'h00000300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_launch_sf", 32'(start_func), 32'h1);
        chk("to_launch_busy", 32'(busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        func_done = 1'b0;
        cyc = 2;
        for (int k = 0; k < WD + 10 && !done; k++) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", 32'(cyc), 32'(WD + 2));
        chk("to_status", 32'(status), 32'h3);
        chk("to_iter", 32'(iter_count), 32'h0);
        chk("to_x", x_cur, 32'h00000300);
        chk("to_busy", 32'(busy), 32'h0);

        // reset in the middle of WAIT, then a clean run
        @(negedge clk);
        x_init = 32'h00000123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        r = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) r++;
        end
        chk("rst_no_done", 32'(r), 32'h0);
        rst_n = 1'b1;
        clear_resp();
        push_resp(32'h0, 1'b0, 2);
        run("restart", 32'h00000200, 1'b0);

        // randomized runs with start toggling while busy
        for (int n = 0; n < 40; n++) begin
            clear_resp();
            for (int k = 0; k < MAX_ITER; k++) begin
                r = int'($urandom_range(0, 9));
                if (r < 2) begin
                    case ($urandom_range(0, 2))
                        0: xr = 32'h0;
                        1: xr = 32'h1;
                        default: xr = 32'hFFFFFFFF;
                    endcase
                end else if (r < 4) begin
                    xr = ($urandom_range(0, 1) == 0) ? 32'h80000000 : $urandom;
                end else begin
                    xr = 32'($urandom_range(0, 32'hFFF)) - 32'h800;
                end
                push_resp(xr, ($urandom_range(0, 7) == 0), int'($urandom_range(1, 5)));
            end
            case ($urandom_range(0, 3))
                0: xr = 32'h7FFFFF00 + 32'($urandom_range(0, 255));
                1: xr = 32'h80000000 + 32'($urandom_range(0, 255));
                default: xr = $urandom;
            endcase
            run($sformatf("rnd%0d", n), xr, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gd_iter_ctrl.md
Name: gd_iter_ctrl

Overview:
- Iteration controller for the fixed-point gradient-descent loop.
- Sits directly downstream of the gradient/step block, whose outputs are the step x_diff, func_done and overflow; also drives that block's x_in and start_func.
- Loads an initial Q24.8 point, repeatedly launches a gradient evaluation, applies x <= sat(x - x_diff), and terminates on one of: convergence, iteration limit, arithmetic overflow, or watchdog timeout.

Parameters:
- MAX_ITER, 256, maximum number of updates before forced stop (1..2^ITER_W-1).
- ITER_W, 16, width of the iteration counter.
- TOL, 32'h00000001, Q24.8 convergence threshold; converged when |x_diff| <= TOL.
- WATCHDOG, 1024, max cycles spent in WAIT before timeout.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run (accepted only in IDLE or DONE).
- x_init, input, 32, signed Q24.8 starting point; sampled when start is accepted.
- x_diff, input, 32, signed Q24.8 step from the gradient block.
- func_done, input, 1, gradient block result valid (level).
- grad_overflow, input, 1, gradient block overflow flag; valid with func_done.
- start_func, output, 1, one-cycle launch pulse to the gradient block.
- x_cur, output, 32, current point; drives the gradient block's x_in.
- iter_count, output, ITER_W, updates applied in the current run.
- busy, output, 1, run in progress.
- done, output, 1, one-cycle pulse at run end.
- status, output, 2, 0=converged, 1=max_iter, 2=overflow, 3=timeout; held until the next start.
- sat_seen, output, 1, sticky: some update clamped during this run.

Behaviour:
- Reset (async, any state): state=IDLE; start_func=0, x_cur=0, iter_count=0, busy=0, done=0, status=0, sat_seen=0, watchdog counter=0.
- States: IDLE, LAUNCH, BLANK, WAIT, UPDATE, DONE.
- IDLE/DONE + start:
  - x_cur<=x_init, iter_count<=0, sat_seen<=0, status<=0.
  - Go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH:
  - start_func=1 for exactly this cycle; x_cur is stable.
  - Go to BLANK.
- BLANK:
  - One cycle; func_done is ignored here, which masks the stale done level from the previous evaluation.
  - Watchdog counter cleared.
  - Go to WAIT.
- WAIT:
  - func_done=1: go to UPDATE and register x_diff and grad_overflow this cycle.
  - Otherwise the watchdog counter increments.
  - Counter reaches WATCHDOG-1 with func_done still 0: status=3, go to DONE.
- UPDATE (single cycle), evaluated in priority order:
  1. Registered grad_overflow=1: status=2, x_cur unchanged, iter_count unchanged, go to DONE.
  2. Otherwise, 33-bit difference d = sext(x_cur) - sext(x_diff):
     - d > 0x7FFFFFFF: x_cur=0x7FFFFFFF, sat_seen=1.
     - d < -0x80000000: x_cur=0x80000000, sat_seen=1.
     - Else x_cur=d[31:0].
     - iter_count increments.
  3. |x_diff| (33-bit abs, so 0x80000000 does not wrap) <= TOL: status=0, go to DONE.
  4. Else if the new iter_count == MAX_ITER: status=1, go to DONE.
  5. Else go to LAUNCH.
- Convergence has priority over max_iter when both hold in the same UPDATE.
- Entering DONE: done=1 for one cycle, busy=0.
  - x_cur, iter_count, status and sat_seen hold.
  - start in DONE behaves as in IDLE; a start in the same cycle done pulses is accepted on the following cycle.
- busy=1 in LAUNCH, BLANK, WAIT and UPDATE.
- Latency per iteration = 3 + gradient-block latency cycles (LAUNCH, BLANK, ≥1 WAIT, UPDATE).
- Reset mid-run aborts immediately; no done pulse is generated.

Test Plan:
- Converge in one step: x_init=0x00000400, model returns x_diff=0 after 3 cycles → done pulses, status=0, iter_count=1, x_cur=0x00000400.
- Iteration limit: MAX_ITER=4, x_init=0x00000100, model x_diff=0x10 constant → status=1, iter_count=4, x_cur=0x000000C0, four start_func pulses.
- Saturation: x_init=0x80000010, x_diff=0x7FFFFFFF, then x_diff=0 → x_cur=0x80000000, sat_seen=1, status=0, iter_count=2.
- Overflow stop: x_diff=0x10 and grad_overflow=1 on the 2nd result, x_init=0x100 → status=2, x_cur=0x000000F0, iter_count=1.
- Timeout and blanking: func_done held at 1 from before start, then forced to 0 after BLANK and never reasserted → no update from the stale level; status=3 exactly WATCHDOG cycles after BLANK.
- Reset mid-WAIT, then restart with x_init=0x200 and x_diff=0 → all outputs at reset values, no done pulse; then a normal run completes with status=0, iter_count=1.
